// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM stage of the 5-stage MIPS pipeline. Takes the EX/MEM latch outputs,
//   runs loads and stores against the data memory over a req/ack handshake,
//   and drives the MEM/WB latch. While an access is pending, upstream stages
//   are held through o_stall.
//
// Optional feature (macro DMEM_TIMEOUT_EN):
//   When defined, the TIMEOUT_CYCLES parameter exists. WAIT aborts after
//   TIMEOUT_CYCLES cycles without ack, pulses o_bus_err, and bubbles MEM/WB.
//   When undefined, WAIT lasts until ack and o_bus_err is tied low.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   i_step                   pipeline advance enable
//   i_ALU_res                effective address / ALU result
//   i_rt_reg                 store data
//   i_pc_to_reg              link value (JAL/JALR)
//   i_addr_reg_dst           destination register
//   is_write_pc              select i_pc_to_reg as write-back data
//   is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead, is_stop_pipe
//                            EX/MEM control bits
//   is_load_store_type       [1:0] size (00 byte, 01 half, 10 word),
//                            [2] unsigned load
//   o_dmem_req/we/addr/wdata/be   data memory request
//   i_dmem_ack, i_dmem_rdata      data memory response
//   o_stall                  hold upstream latches
//   o_misaligned             1-cycle pulse: misaligned access dropped
//   o_bus_err                1-cycle pulse: timeout abort
//   o_wb_data, o_wb_addr_reg_dst, os_wb_RegWrite, os_wb_stop_pipe
//                            MEM/WB latch outputs
// -----------------------------------------------------------------------------
module mem_access_unit
`ifdef DMEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_step,
  input  logic [31:0] i_ALU_res,
  input  logic [31:0] i_rt_reg,
  input  logic [31:0] i_pc_to_reg,
  input  logic [4:0]  i_addr_reg_dst,
  input  logic        is_write_pc,
  input  logic        is_RegWrite,
  input  logic        is_MemtoReg,
  input  logic        is_MemWrite,
  input  logic        is_MemRead,
  input  logic        is_stop_pipe,
  input  logic [2:0]  is_load_store_type,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_addr_reg_dst,
  output logic        os_wb_RegWrite,
  output logic        os_wb_stop_pipe
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      r_state;
  state_t      w_next_state;

  // Request registers, captured when the access is launched
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [2:0]  r_type;
  logic [4:0]  r_dst;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic        r_stop;

  // MEM/WB latch
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_dst;
  logic        r_wb_regwrite;
  logic        r_wb_stop;
  logic        r_misaligned;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_issue;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_mem_op     = is_MemRead | is_MemWrite;
  assign w_misaligned = ((is_load_store_type[1:0] == 2'b01) & i_ALU_res[0]) |
                        (is_load_store_type[1] & (|i_ALU_res[1:0]));
  assign w_issue      = i_step & w_mem_op & ~w_misaligned;

  // Store lane placement; loads always fetch the full word
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_rt_reg;
    case (is_load_store_type[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_ALU_res[1:0];
        w_wdata = {4{i_rt_reg[7:0]}};
      end
      2'b01: begin
        w_be    = i_ALU_res[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_rt_reg[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_rt_reg;
      end
    endcase
    if (!is_MemWrite) begin
      w_be = 4'b1111;
    end
  end

  // Load extraction from the returned word using the captured address/type
  always_comb begin
    w_byte      = '0;
    w_half      = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    w_load_data = i_dmem_rdata;
    case (r_addr[1:0])
      2'b00:   w_byte = i_dmem_rdata[7:0];
      2'b01:   w_byte = i_dmem_rdata[15:8];
      2'b10:   w_byte = i_dmem_rdata[23:16];
      default: w_byte = i_dmem_rdata[31:24];
    endcase
    case (r_type[1:0])
      2'b00:   w_load_data = r_type[2] ? {24'h000000, w_byte}
                                       : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_type[2] ? {16'h0000, w_half}
                                       : {{16{w_half[15]}}, w_half};
      default: w_load_data = i_dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional timeout
  // ---------------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_bus_err;

  // r_cnt counts completed WAIT cycles, so TO_LAST marks the final one
  assign w_timeout = (r_state == ST_WAIT) & ~i_dmem_ack & (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_next_state = ST_WAIT;
      ST_WAIT: if (i_dmem_ack || w_timeout) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs. Stall is gated by reset so it drops as soon as reset asserts.
  always_comb begin
    o_dmem_req = 1'b0;
    o_stall    = 1'b0;
    case (r_state)
      ST_IDLE: o_stall = w_issue & rst;
      ST_WAIT: begin
        o_dmem_req = 1'b1;
        o_stall    = ~i_dmem_ack & ~w_timeout & rst;
      end
      default: begin
        o_dmem_req = 1'b0;
        o_stall    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_we       <= 1'b0;
      r_type     <= '0;
      r_dst      <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_stop     <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_issue) begin
      r_addr     <= i_ALU_res;
      r_wdata    <= w_wdata;
      r_be       <= w_be;
      r_we       <= is_MemWrite;
      r_type     <= is_load_store_type;
      r_dst      <= i_addr_reg_dst;
      r_regwrite <= is_RegWrite;
      r_memtoreg <= is_MemtoReg;
      r_stop     <= is_stop_pipe;
    end
  end

  assign o_dmem_we    = r_we;
  assign o_dmem_addr  = {r_addr[31:2], 2'b00};
  assign o_dmem_wdata = r_wdata;
  assign o_dmem_be    = r_be;

  // ---------------------------------------------------------------------------
  // MEM/WB latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_data     <= '0;
      r_wb_dst      <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_stop     <= 1'b0;
      r_misaligned  <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      if (r_state == ST_WAIT) begin
        if (i_dmem_ack) begin
          r_wb_data     <= r_memtoreg ? w_load_data : r_addr;
          r_wb_dst      <= r_dst;
          r_wb_regwrite <= r_regwrite;
          r_wb_stop     <= r_stop;
        end else begin
          r_wb_data     <= '0;
          r_wb_dst      <= '0;
          r_wb_regwrite <= 1'b0;
          r_wb_stop     <= 1'b0;
        end
      end else if (i_step) begin
        if (!w_mem_op) begin
          r_wb_data     <= is_write_pc ? i_pc_to_reg : i_ALU_res;
          r_wb_dst      <= i_addr_reg_dst;
          r_wb_regwrite <= is_RegWrite;
          r_wb_stop     <= is_stop_pipe;
        end else if (w_misaligned) begin
          // Dropped access still carries the halt marker down the pipe
          r_wb_data     <= '0;
          r_wb_dst      <= '0;
          r_wb_regwrite <= 1'b0;
          r_wb_stop     <= is_stop_pipe;
          r_misaligned  <= 1'b1;
        end else begin
          r_wb_data     <= '0;
          r_wb_dst      <= '0;
          r_wb_regwrite <= 1'b0;
          r_wb_stop     <= 1'b0;
        end
      end
    end
  end

  assign o_wb_data         = r_wb_data;
  assign o_wb_addr_reg_dst = r_wb_dst;
  assign os_wb_RegWrite    = r_wb_regwrite;
  assign os_wb_stop_pipe   = r_wb_stop;
  assign o_misaligned      = r_misaligned;

endmodule
